// File: rtl/tt_um_nibble_link_rx_if.sv
// Pin bundle of the nibble-link receiver: the Tiny Tapeout user-project I/O bus.
// The master modport drives the pins into the block and the slave modport is the receiver side.
interface tt_um_nibble_link_rx_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_nibble_link_rx.sv
// Inverted-nibble link receiver: pairs nibbles (low then high) into bytes and queues them in a FIFO.
// Optional odd-parity checking of each nibble is enabled by defining PARITY_CHECK_EN.
module tt_um_nibble_link_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_um_nibble_link_rx_if.slave io
);
  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam int         SW       = 9;
  localparam logic [1:0] ST_LO    = 2'd0;
  localparam logic [1:0] ST_HI    = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    lo_nib_q, lo_nib_d;
  logic          lo_bad_q, lo_bad_d;
  logic          perr_q, perr_d;
  logic          stb_prev_q, stb_prev_d;
  logic          pop_prev_q, pop_prev_d;
  logic          ack_q, ack_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic [SW-1:0] sync_out;
  logic [3:0]    nibble;
  logic          stb_s, pop_s, flush_s, view_s;
  logic          nib_event, nib_bad, full, empty, push, pop_fire;
  logic [7:0]    status;

  // Synchronized bits: {VIEW, FLUSH, POP, PAR, STB, DATA_N[3:0]}.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {io.ui_in[2:0], io.uio_in[5:0]};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign nibble    = ~sync_out[3:0];
  assign stb_s     = sync_out[4];
  assign pop_s     = sync_out[6];
  assign flush_s   = sync_out[7];
  assign view_s    = sync_out[8];
  assign nib_event = stb_s != stb_prev_q;
  assign full      = count_q == 3'(FIFO_DEPTH);
  assign empty     = count_q == 3'd0;

`ifdef PARITY_CHECK_EN
  // The line carries odd parity over {DATA_N, PAR}.
  assign nib_bad = ~^sync_out[5:0];
`else
  logic unused_par;
  assign unused_par = sync_out[5];
  assign nib_bad    = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    lo_nib_d   = lo_nib_q;
    lo_bad_d   = lo_bad_q;
    perr_d     = perr_q;
    stb_prev_d = stb_prev_q;
    pop_prev_d = pop_s;
    ack_d      = ack_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    push       = 1'b0;
    pop_fire   = 1'b0;

    if (flush_s) begin
      state_d    = ST_LO;
      lo_nib_d   = '0;
      lo_bad_d   = 1'b0;
      perr_d     = 1'b0;
      stb_prev_d = stb_s;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        ST_LO: if (nib_event) begin
          lo_nib_d   = nibble;
          lo_bad_d   = nib_bad;
          perr_d     = perr_q | nib_bad;
          ack_d      = ~ack_q;
          stb_prev_d = stb_s;
          state_d    = ST_HI;
        end
        ST_HI: if (nib_event) begin
          // A bad byte is dropped here and never waits for FIFO space.
          if (lo_bad_q || nib_bad) begin
            perr_d     = perr_q | nib_bad;
            ack_d      = ~ack_q;
            stb_prev_d = stb_s;
            state_d    = ST_LO;
          end else if (!full) begin
            push       = 1'b1;
            ack_d      = ~ack_q;
            stb_prev_d = stb_s;
            state_d    = ST_LO;
          end else begin
            state_d = ST_STALL;
          end
        end
        ST_STALL: if (!full) begin
          push       = 1'b1;
          ack_d      = ~ack_q;
          stb_prev_d = stb_s;
          state_d    = ST_LO;
        end
        default: state_d = ST_LO;
      endcase

      pop_fire = pop_s && !pop_prev_q && !empty;
      if (push) begin
        mem_d[wr_ptr_q] = {nibble, lo_nib_q};
        wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_fire) rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop_fire})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= ST_LO;
      lo_nib_q   <= '0;
      lo_bad_q   <= 1'b0;
      perr_q     <= 1'b0;
      stb_prev_q <= 1'b0;
      pop_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      // NOTE: the FIFO storage is only a few bytes, so it is reset too and uo_out never shows X.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      sync_q     <= sync_d;
      state_q    <= state_d;
      lo_nib_q   <= lo_nib_d;
      lo_bad_q   <= lo_bad_d;
      perr_q     <= perr_d;
      stb_prev_q <= stb_prev_d;
      pop_prev_q <= pop_prev_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign status     = {count_q, perr_q, state_q == ST_HI, state_q == ST_STALL, full, empty};
  assign io.uo_out  = view_s ? status : (empty ? 8'h00 : mem_q[rd_ptr_q]);
  assign io.uio_out = {full, ack_q, 6'b0};
  assign io.uio_oe  = 8'hC0;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, io.ena, io.ui_in[7:3], io.uio_in[7:6]};
endmodule

// File: tb/tb_tt_um_nibble_link_rx.sv
// Self-checking bench for tt_um_nibble_link_rx: directed protocol steps plus a randomized phase,
// compared against a queue-based model of the link (parity expectations follow PARITY_CHECK_EN).
module tb_tt_um_nibble_link_rx;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic clk;
  logic rst_n;
  tt_um_nibble_link_rx_if bus ();

  tt_um_nibble_link_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued bytes plus the visible protocol flags.
  logic [7:0] q[$];
  logic       perr_m  = 1'b0;
  logic       hi_m    = 1'b0;
  logic       stall_m = 1'b0;
  logic       ack_m   = 1'b0;
  logic       stb_lvl = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] exp_status();
    logic full_m, empty_m;
    full_m  = q.size() == DEPTH;
    empty_m = q.size() == 0;
    return {3'(q.size()), perr_m, hi_m, stall_m, full_m, empty_m};
  endfunction

  function automatic logic [7:0] exp_head();
    logic [7:0] h;
    h = 8'h00;
    if (q.size() != 0) h = q[0];
    return h;
  endfunction

  task automatic wait_ack(input int budget, output int edges);
    logic a0;
    a0    = bus.uio_out[6];
    edges = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (bus.uio_out[6] !== a0) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bus.ui_in[2] = 1'b0;
    tick(SYNC + 1);
    check({tag, "_head"}, bus.uo_out, exp_head());
    check({tag, "_ack"}, bus.uio_out[6], ack_m);
    check({tag, "_full"}, bus.uio_out[7], q.size() == DEPTH);
    bus.ui_in[2] = 1'b1;
    tick(SYNC + 1);
    check({tag, "_status"}, bus.uo_out, exp_status());
    bus.ui_in[2] = 1'b0;
  endtask

  // Put a nibble on the line, honour the setup time, then toggle STB.
  task automatic present_nibble(input logic [3:0] nib, input bit par_ok);
    logic [3:0] dn;
    dn = ~nib;
    bus.uio_in[3:0] = dn;
    bus.uio_in[5]   = par_ok ? ~(^dn) : ^dn;
    tick(SYNC + 1);
    stb_lvl       = ~stb_lvl;
    bus.uio_in[4] = stb_lvl;
  endtask

  task automatic send_nibble(input logic [3:0] nib, input bit par_ok);
    int e;
    present_nibble(nib, par_ok);
    wait_ack(12, e);
    check("ack_latency", e, SYNC + 1);
    ack_m = ~ack_m;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok_lo, input bit ok_hi);
    bit bad;
    send_nibble(b[3:0], ok_lo);
    send_nibble(b[7:4], ok_hi);
    bad = 1'b0;
`ifdef PARITY_CHECK_EN
    if (!ok_lo || !ok_hi) begin
      perr_m = 1'b1;
      bad    = 1'b1;
    end
`endif
    if (!bad) q.push_back(b);
  endtask

  task automatic do_pop();
    bus.ui_in[0] = 1'b1;
    tick(SYNC + 2);
    bus.ui_in[0] = 1'b0;
    tick(SYNC + 2);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  initial begin
    int e;
    logic [7:0] b;
    bit ok_lo, ok_hi;

    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.ui_in   = 8'h00;
    bus.uio_in  = 8'h00;
    tick(3);
    check("rst_uo_out", bus.uo_out, 8'h00);
    check("rst_uio_out", bus.uio_out, 8'h00);
    check("rst_uio_oe", bus.uio_oe, 8'hC0);
    rst_n = 1'b1;
    check_outputs("reset");

    // Basic byte: low 0xA then high 0x5.
    send_byte(8'h5A, 1'b1, 1'b1);
    check_outputs("byte_5a");
    do_pop();
    check_outputs("drain_5a");

    // Fill, then stall on the fifth byte until a pop frees a slot.
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b1);
    check_outputs("full");
    send_nibble(4'h5, 1'b1);
    present_nibble(4'h5, 1'b1);
    wait_ack(12, e);
    check("stall_no_ack", e, -1);
    stall_m = 1'b1;
    check_outputs("stalled");
    bus.ui_in[0] = 1'b1;
    wait_ack(12, e);
    check("stall_release_latency", e, SYNC + 2);
    bus.ui_in[0] = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h55);
    stall_m = 1'b0;
    ack_m   = ~ack_m;
    tick(SYNC + 2);
    check_outputs("after_stall");
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check_outputs("drain");
    end

    // Pop on empty does nothing; the next byte still lands at the head.
    do_pop();
    check_outputs("pop_empty");

    // Push and pop reaching the FSM on the same edge at count 2.
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    send_nibble(4'h3, 1'b1);
    present_nibble(4'h3, 1'b1);
    bus.ui_in[0] = 1'b1;
    wait_ack(12, e);
    check("push_pop_latency", e, SYNC + 1);
    ack_m = ~ack_m;
    void'(q.pop_front());
    q.push_back(8'h33);
    bus.ui_in[0] = 1'b0;
    tick(SYNC + 2);
    check_outputs("push_pop");

    // Flush discards a partial byte and drops a strobe seen while it is high.
    send_nibble(4'h3, 1'b1);
    hi_m = 1'b1;
    check_outputs("half_byte");
    bus.ui_in[1]  = 1'b1;
    bus.uio_in[3:0] = 4'h9;
    stb_lvl       = ~stb_lvl;
    bus.uio_in[4] = stb_lvl;
    tick(4);
    check("flush_ack_held", bus.uio_out[6], ack_m);
    bus.ui_in[1] = 1'b0;
    tick(SYNC + 2);
    q.delete();
    hi_m   = 1'b0;
    perr_m = 1'b0;
    check_outputs("flushed");
    send_byte(8'hC3, 1'b1, 1'b1);
    check_outputs("after_flush");

    // Wrong parity on the high nibble.
    send_byte(8'hB7, 1'b1, 1'b0);
    check_outputs("parity_hi");

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0 && q.size() < DEPTH) begin
        b     = 8'($urandom);
        ok_lo = $urandom_range(0, 7) != 0;
        ok_hi = $urandom_range(0, 7) != 0;
        send_byte(b, ok_lo, ok_hi);
      end else begin
        do_pop();
      end
      check_outputs("rand");
    end

    // Reset in the middle of a byte returns everything to idle.
    send_nibble(4'hE, 1'b1);
    rst_n = 1'b0;
    tick(2);
    q.delete();
    perr_m  = 1'b0;
    ack_m   = 1'b0;
    hi_m    = 1'b0;
    stb_lvl = 1'b0;
    bus.uio_in = 8'h00;
    check("midreset_uio_out", bus.uio_out, 8'h00);
    rst_n = 1'b1;
    check_outputs("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
